moving_stats_window: RTL and testbench

MOVING_STATS_WINDOW -- requirements
Module: moving_stats_window

---
 rtl/moving_stats_window.sv | 191 +++++++++++++++++++
 tb/tb_moving_stats_window.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/moving_stats_window.sv
// rtl/moving_stats_window.sv - sliding-window mean, variance and standard deviation
//
// Purpose: keeps the last W = 2**LOG2_WINDOW unsigned samples in a circular
// buffer with running sum and sum of squares. Each accepted sample produces one
// result: floor mean, floored population variance and, optionally, the floor
// square root of the variance.
//
// Optional feature macro: MOVING_STATS_STDDEV_EN
//   defined   - restoring square root, one bit per cycle (o_valid at k+3+DATA_WIDTH)
//   undefined - no root logic, o_stddev tied to 0 (o_valid at k+3)
//
// Ports:
//   i_clk         clock, rising edge
//   i_reset       synchronous active-high reset
//   i_clear       synchronous window flush
//   i_valid       sample offered
//   i_data        sample value
//   o_ready       high only while IDLE
//   o_valid       one-cycle result strobe
//   o_mean        floor(sum / W)
//   o_variance    floored population variance
//   o_stddev      floor(sqrt(o_variance))
//   o_window_full W samples held since reset/clear
module moving_stats_window #(
  parameter int DATA_WIDTH  = 32,
  parameter int LOG2_WINDOW = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clear,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_mean,
  output logic [2*DATA_WIDTH-1:0] o_variance,
  output logic [DATA_WIDTH-1:0]   o_stddev,
  output logic                    o_window_full
);

  localparam int W  = 1 << LOG2_WINDOW;
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;                    // square / variance width
  localparam int SW = DATA_WIDTH + LOG2_WINDOW;          // sum width
  localparam int QW = 2 * DATA_WIDTH + LOG2_WINDOW;      // sum of squares width
  localparam int VW = 2 * DATA_WIDTH + 2 * LOG2_WINDOW;  // exact variance numerator width
  localparam logic [LOG2_WINDOW:0] FULL_COUNT = (LOG2_WINDOW + 1)'(W);

  typedef enum logic [2:0] {IDLE, UPDATE, CALC, SQRT, DONE} state_t;

  state_t                 state;
  logic [DW-1:0]          buffer [W];
  logic [LOG2_WINDOW-1:0] wr_ptr;
  logic [LOG2_WINDOW:0]   count;
  logic [SW-1:0]          sum;
  logic [QW-1:0]          sumsq;
  logic [DW-1:0]          sample;

  logic [DW-1:0]          out_sample;
  logic [PW-1:0]          in_sq;
  logic [PW-1:0]          out_sq;
  logic [SW-1:0]          sum_next;
  logic [QW-1:0]          sumsq_next;
  logic [LOG2_WINDOW:0]   count_next;
  logic [DW-1:0]          mean_calc;
  logic [VW-1:0]          var_full;
  logic [PW-1:0]          variance_calc;

  assign o_ready = (state == IDLE);

  // Before the window fills, the slot being overwritten still counts as zero.
  assign out_sample = (count == FULL_COUNT) ? buffer[wr_ptr] : '0;
  assign in_sq      = PW'(sample) * PW'(sample);
  assign out_sq     = PW'(out_sample) * PW'(out_sample);
  assign sum_next   = sum + SW'(sample) - SW'(out_sample);
  assign sumsq_next = sumsq + QW'(in_sq) - QW'(out_sq);
  assign count_next = (count == FULL_COUNT) ? count : count + 1'b1;

  // W*sumsq - sum^2 is exact at VW bits and never negative (Cauchy-Schwarz),
  // so dividing by W*W leaves a value that fits the variance port.
  assign mean_calc     = DW'(sum >> LOG2_WINDOW);
  assign var_full      = (VW'(sumsq) << LOG2_WINDOW) - VW'(sum) * VW'(sum);
  assign variance_calc = PW'(var_full >> (2 * LOG2_WINDOW));

`ifdef MOVING_STATS_STDDEV_EN
  localparam int IW = $clog2(DATA_WIDTH);

  logic [DW-1:0] mean_r;
  logic [PW-1:0] var_r;
  logic [PW-1:0] rad;
  logic [DW-1:0] rem;
  logic [DW-1:0] root;
  logic [IW-1:0] iter;
  logic [DW+1:0] rem_shift;
  logic [DW+1:0] trial;
  logic          root_bit;

  // Remainder stays below 2**DW until the final iteration, whose remainder is
  // discarded, so a DW-bit register is enough.
  assign rem_shift = {rem, rad[PW-1:PW-2]};
  assign trial     = {root, 2'b01};
  assign root_bit  = (rem_shift >= trial);
`else
  assign o_stddev = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      count         <= '0;
      sum           <= '0;
      sumsq         <= '0;
      o_valid       <= 1'b0;
      o_mean        <= '0;
      o_variance    <= '0;
      o_window_full <= 1'b0;
`ifdef MOVING_STATS_STDDEV_EN
      o_stddev      <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      if (i_clear) begin
        // Flush the window; a sample offered in the same IDLE cycle becomes
        // the first entry of the empty window.
        wr_ptr        <= '0;
        count         <= '0;
        sum           <= '0;
        sumsq         <= '0;
        o_window_full <= 1'b0;
        state         <= IDLE;
        if (i_valid && state == IDLE) begin
          sample <= i_data;
          state  <= UPDATE;
        end
      end else begin
        case (state)
          IDLE: begin
            if (i_valid) begin
              sample <= i_data;
              state  <= UPDATE;
            end
          end
          UPDATE: begin
            buffer[wr_ptr] <= sample;
            wr_ptr         <= wr_ptr + LOG2_WINDOW'(1);
            sum            <= sum_next;
            sumsq          <= sumsq_next;
            count          <= count_next;
            o_window_full  <= (count_next == FULL_COUNT);
            state          <= CALC;
          end
          CALC: begin
`ifdef MOVING_STATS_STDDEV_EN
            mean_r <= mean_calc;
            var_r  <= variance_calc;
            rad    <= variance_calc;
            rem    <= '0;
            root   <= '0;
            iter   <= '0;
            state  <= SQRT;
`else
            o_mean     <= mean_calc;
            o_variance <= variance_calc;
            o_valid    <= 1'b1;
            state      <= DONE;
`endif
          end
`ifdef MOVING_STATS_STDDEV_EN
          SQRT: begin
            rad  <= rad << 2;
            rem  <= root_bit ? DW'(rem_shift - trial) : DW'(rem_shift);
            root <= {root[DW-2:0], root_bit};
            iter <= iter + IW'(1);
            if (iter == IW'(DW - 1)) begin
              o_mean     <= mean_r;
              o_variance <= var_r;
              o_stddev   <= {root[DW-2:0], root_bit};
              o_valid    <= 1'b1;
              state      <= DONE;
            end
          end
`endif
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moving_stats_window.sv
// tb/tb_moving_stats_window.sv - directed self-checking bench for moving_stats_window
module tb_moving_stats_window;

  localparam int DW = 16;
  localparam int L  = 2;
`ifdef MOVING_STATS_STDDEV_EN
  localparam bit STD_EN = 1'b1;
`else
  localparam bit STD_EN = 1'b0;
`endif
  localparam int LAT = STD_EN ? 3 + DW : 3;
  localparam int MID = STD_EN ? 8 : 2;

  logic          clk;
  logic          i_reset;
  logic          i_clear;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          o_valid;
  logic [DW-1:0] o_mean;
  logic [2*DW-1:0] o_variance;
  logic [DW-1:0] o_stddev;
  logic          o_window_full;

  int checks   = 0;
  int failures = 0;

  moving_stats_window #(.DATA_WIDTH(DW), .LOG2_WINDOW(L)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_clear      (i_clear),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_mean       (o_mean),
    .o_variance   (o_variance),
    .o_stddev     (o_stddev),
    .o_window_full(o_window_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  // Offers a sample at a negedge; returns at the negedge after the accept edge.
  task automatic accept(input logic [DW-1:0] d, input bit clr);
    @(negedge clk);
    check("ready_before_accept", o_ready, 1);
    i_valid = 1'b1;
    i_clear = clr;
    i_data  = d;
    @(negedge clk);
    i_valid = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic run(input logic [DW-1:0] d, input bit clr, input bit inject, input bit chk_res,
                     input logic [DW-1:0] em, input logic [2*DW-1:0] ev,
                     input logic [DW-1:0] es, input bit ef);
    int lat;
    accept(d, clr);
    lat = 1;
    while (!o_valid && lat < LAT + 20) begin
      if (inject && lat == 2) begin
        i_valid = 1'b1;
        i_data  = 16'd100;
      end
      @(negedge clk);
      i_valid = 1'b0;
      lat++;
    end
    check("latency", lat, LAT);
    if (chk_res) begin
      check("mean", o_mean, em);
      check("variance", o_variance, ev);
      check("stddev", o_stddev, STD_EN ? es : 16'd0);
      check("window_full", o_window_full, ef);
    end
    @(negedge clk);
    check("valid_one_cycle", o_valid, 0);
    check("ready_after_done", o_ready, 1);
  endtask

  task automatic abort_mid(input bit use_reset, input logic [DW-1:0] em, input logic [2*DW-1:0] ev);
    bit saw;
    accept(16'd5, 1'b0);
    repeat (MID - 1) @(negedge clk);
    if (use_reset) i_reset = 1'b1;
    else           i_clear = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    i_clear = 1'b0;
    check("abort_ready", o_ready, 1);
    check("abort_valid", o_valid, 0);
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (o_valid) saw = 1'b1;
    end
    check("abort_no_valid", saw, 0);
    check("abort_mean_kept", o_mean, em);
    check("abort_var_kept", o_variance, ev);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1;
    i_clear = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    do_reset();
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_mean", o_mean, 0);
    check("rst_variance", o_variance, 0);
    check("rst_stddev", o_stddev, 0);
    check("rst_full", o_window_full, 0);

    // Fill window 2,4,6,8 (ignored sample injected mid-processing of 4), then wrap with 10.
    run(16'd2,  0, 0, 1, 16'd0, 32'd0, 16'd0, 1'b0);
    run(16'd4,  0, 1, 1, 16'd1, 32'd2, 16'd1, 1'b0);
    run(16'd6,  0, 0, 1, 16'd3, 32'd5, 16'd2, 1'b0);
    run(16'd8,  0, 0, 1, 16'd5, 32'd5, 16'd2, 1'b1);
    run(16'd10, 0, 0, 1, 16'd7, 32'd5, 16'd2, 1'b1);

    // Clear mid-processing: no strobe, previous results retained, window emptied.
    abort_mid(1'b0, 16'd7, 32'd5);
    run(16'd8, 0, 0, 1, 16'd2, 32'd12, 16'd3, 1'b0);

    // Full-scale samples must not overflow.
    do_reset();
    run(16'hFFFF, 0, 0, 1, 16'h3FFF, 32'd805281792, 16'd28377, 1'b0);
    run(16'hFFFF, 0, 0, 0, 16'd0, 32'd0, 16'd0, 1'b0);
    run(16'hFFFF, 0, 0, 0, 16'd0, 32'd0, 16'd0, 1'b0);
    run(16'hFFFF, 0, 0, 1, 16'hFFFF, 32'd0, 16'd0, 1'b1);

    // Clear together with a sample: sample becomes the first of an empty window.
    run(16'd8, 1, 0, 1, 16'd2, 32'd12, 16'd3, 1'b0);

    // Reset mid-processing: no strobe, results zeroed.
    abort_mid(1'b1, 16'd0, 32'd0);
    check("post_reset_full", o_window_full, 0);
    run(16'd8, 0, 0, 1, 16'd2, 32'd12, 16'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
